display_scan: RTL and testbench

Four-digit multiplexed scanner that sits directly upstream of the 7-segment decoder. It accepts a 14-bit binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a single 4-bit `number` bus that feeds the decoder, and drives matching active-low digit enables. Values above 9999 display as four dashes, using digit code 4'hf.

---
 rtl/display_scan.sv | 99 +++++++++
 tb/tb_display_scan.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit BCD scanner: load accepted only in IDLE, display registers update 15 cycles later.
// Loads arriving while busy are dropped (no queue); the digit scan free-runs regardless of conversion.
module display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  number,
  output logic [3:0]  an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [13:0]     bin_q;
  logic [15:0]     bcd_q;
  logic [15:0]     bcd_adj;
  logic [3:0]      bit_cnt;
  logic            ovf_q;
  logic [3:0][3:0] disp_q;
  logic [CW-1:0]   scan_cnt;
  logic [1:0]      scan_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV;
      CONV:    if (bit_cnt == 4'd13) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction keeps every nibble a legal BCD digit after the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_cnt <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_q   <= value;
            bcd_q   <= '0;
            bit_cnt <= '0;
            ovf_q   <= (value > 14'd9999);
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          bit_cnt        <= bit_cnt + 4'd1;
        end
        COMMIT: begin
          // Overflowed values still run the full conversion so timing stays uniform.
          disp_q <= ovf_q ? '1 : bcd_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == TERM) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign busy   = (state != IDLE);
  assign an     = ~(4'b0001 << scan_idx);
  assign number = disp_q[scan_idx];

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: three instances (SCAN_DIV 1, 2, 4) share stimulus;
// a decimal reference model predicts commits, busy windows and the scanned digits.
module tb_display_scan;

  localparam int DIVS [3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy_w [3];
  logic [3:0]  num_w  [3];
  logic [3:0]  an_w   [3];

  display_scan #(.SCAN_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_w[0]), .number(num_w[0]), .an(an_w[0])
  );
  display_scan #(.SCAN_DIV(2)) u_div2 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_w[1]), .number(num_w[1]), .an(an_w[1])
  );
  display_scan #(.SCAN_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_w[2]), .number(num_w[2]), .an(an_w[2])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    int          commit;
  } exp_t;

  exp_t        q [$];
  int          checks = 0;
  int          errors = 0;
  int          tcyc = 0;
  int          free_at = 0;
  logic [15:0] disp_exp = 16'hffff;
  logic        prev_busy = 1'b0;

  function automatic logic [15:0] ref_digits(int v);
    if (v > 9999) return 16'hffff;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges since reset release and decides which loads are taken.
  always @(posedge clk) begin
    if (!rst_n) begin
      tcyc    = 0;
      free_at = 0;
      q.delete();
    end else begin
      tcyc = tcyc + 1;
      if (load && tcyc >= free_at) begin
        q.push_back('{digits: ref_digits(int'(value)), commit: tcyc + 15});
        free_at = tcyc + 16;
      end
    end
  end

  // Monitor: pops an expectation when busy falls, then checks scan and digits every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      disp_exp  = 16'hffff;
      prev_busy = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_an_div%0d", DIVS[k]), an_w[k], 4'he);
        chk($sformatf("rst_number_div%0d", DIVS[k]), num_w[k], 4'hf);
        chk($sformatf("rst_busy_div%0d", DIVS[k]), busy_w[k], 1'b0);
      end
    end else begin
      if (prev_busy && !busy_w[0]) begin
        chk("commit_pending", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("commit_edge", tcyc, e.commit);
          disp_exp = e.digits;
        end
      end
      if (q.size() > 0 && tcyc > q[0].commit + 1) begin
        chk("commit_timeout", tcyc, q[0].commit);
        void'(q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (tcyc / DIVS[k]) % 4;
        chk($sformatf("an_div%0d", DIVS[k]), an_w[k], ~(4'b0001 << idx) & 4'hf);
        chk($sformatf("number_div%0d", DIVS[k]), num_w[k], disp_exp[4*idx +: 4]);
        chk($sformatf("busy_div%0d", DIVS[k]), busy_w[k], tcyc < free_at - 1);
      end
      prev_busy = busy_w[0];
    end
  end

  task automatic pulse(int v);
    value = 14'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int bounds [6] = '{1234, 9999, 10000, 16383, 0, 42};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    foreach (bounds[i]) begin
      @(negedge clk);
      pulse(bounds[i]);
      repeat (36) @(negedge clk);
    end

    // Second load three cycles in is dropped; the one on the first idle edge is taken.
    @(negedge clk);
    pulse(5678);
    repeat (2) @(negedge clk);
    pulse(1111);
    repeat (12) @(negedge clk);
    pulse(1111);
    repeat (40) @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      pulse($urandom_range(0, 16383));
      repeat ($urandom_range(0, 24)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    // Reset in the middle of a conversion.
    pulse(8765);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_an_div%0d", DIVS[k]), an_w[k], 4'he);
      chk($sformatf("midrst_number_div%0d", DIVS[k]), num_w[k], 4'hf);
      chk($sformatf("midrst_busy_div%0d", DIVS[k]), busy_w[k], 1'b0);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);

    for (int n = 0; n < 15; n++) begin
      pulse($urandom_range(0, 16383));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (60) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
